// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between instruction fetch and data access, data first.
// Define MEMORY_ARBITER_STARVE_GUARD_EN to force a fetch grant after STARVE_MAX data grants.
module memory_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready
);
    typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;
    state_t state, next_state;
    logic dreq, istarve;
    assign dreq = dREN | dWEN;
`ifdef MEMORY_ARBITER_STARVE_GUARD_EN
    localparam int CW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
    logic [CW-1:0] starve_cnt;
    assign istarve = iREN && (starve_cnt == CW'(STARVE_MAX));
    // Counts data grants won while a fetch was waiting; reset by any fetch grant or idle fetch port.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            starve_cnt <= '0;
        else if (state == IDLE) begin
            if (!iREN || next_state == IACC)
                starve_cnt <= '0;
            else if (next_state == DACC)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign istarve = 1'b0;
`endif
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= next_state;
    end
    always_comb begin
        next_state = state;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        ram_ren    = 1'b0;
        ram_wen    = 1'b0;
        ram_addr   = '0;
        ram_store  = '0;
        case (state)
            IDLE: next_state = (dreq && !istarve) ? DACC : iREN ? IACC : IDLE;
            IACC: begin
                ram_addr   = iaddr;
                ram_ren    = iREN;
                iwait      = !(iREN && ram_ready);
                iload      = (iREN && ram_ready) ? ram_load : '0;
                next_state = (!iREN || ram_ready) ? IDLE : IACC;
            end
            DACC: begin
                ram_addr   = daddr;
                ram_store  = dstore;
                ram_wen    = dWEN;
                ram_ren    = dREN && !dWEN;
                dwait      = !(dreq && ram_ready);
                dload      = (dREN && !dWEN && ram_ready) ? ram_load : '0;
                next_state = (!dreq || ram_ready) ? IDLE : DACC;
            end
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed vectors with hand-computed expectations for memory_arbiter.
module tb_memory_arbiter;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN, ram_ready;
    logic [31:0] iaddr, daddr, dstore, ram_load;
    logic        iwait, dwait, ram_ren, ram_wen;
    logic [31:0] iload, dload, ram_addr, ram_store;
    int vectors = 0;
    int miscompares = 0;
    int first_i;

    memory_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
        iaddr = 0; daddr = 0; dstore = 0; ram_load = 32'hFFFF_FFFF;
        settle();
        check("rst_iwait", iwait, 1);
        check("rst_dwait", dwait, 1);
        check("rst_ren", ram_ren, 0);
        check("rst_wen", ram_wen, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_iload", iload, 0);
        tick(); tick();
        nRST = 1'b1;
        tick();

        // single fetch, ready two cycles after grant
        iREN = 1; iaddr = 32'h0000_0040; settle();
        check("f_idle_ren", ram_ren, 0);
        check("f_idle_iwait", iwait, 1);
        tick(); settle();
        check("f_grant_ren", ram_ren, 1);
        check("f_grant_addr", ram_addr, 32'h40);
        check("f_grant_iwait", iwait, 1);
        tick(); settle();
        check("f_wait_iwait", iwait, 1);
        tick(); ram_ready = 1; ram_load = 32'h2408_0005; settle();
        check("f_done_iwait", iwait, 0);
        check("f_done_iload", iload, 32'h2408_0005);
        check("f_done_dwait", dwait, 1);
        tick(); settle();
        check("f_turn_ren", ram_ren, 0);
        check("f_turn_iwait", iwait, 1);
        check("f_turn_iload", iload, 0);
        iREN = 0; ram_ready = 0;
        tick();

        // collision: data wins, fetch after one idle cycle
        iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h100; settle();
        tick(); settle();
        check("c_dacc_addr", ram_addr, 32'h100);
        check("c_dacc_ren", ram_ren, 1);
        ram_ready = 1; ram_load = 32'h1122_3344; settle();
        check("c_dwait", dwait, 0);
        check("c_dload", dload, 32'h1122_3344);
        check("c_iwait", iwait, 1);
        check("c_iload", iload, 0);
        tick(); dREN = 0; ram_ready = 0; settle();
        check("c_idle_ren", ram_ren, 0);
        check("c_idle_dwait", dwait, 1);
        tick(); settle();
        check("c_iacc_addr", ram_addr, 32'h80);
        check("c_iacc_ren", ram_ren, 1);
        ram_ready = 1; ram_load = 32'hCAFE_0001; settle();
        check("c_iacc_iload", iload, 32'hCAFE_0001);
        tick(); iREN = 0; ram_ready = 0;
        tick();

        // write has precedence over read
        dREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'hDEAD_BEEF; settle();
        tick(); settle();
        check("w_wen", ram_wen, 1);
        check("w_ren", ram_ren, 0);
        check("w_store", ram_store, 32'hDEAD_BEEF);
        check("w_addr", ram_addr, 32'h200);
        check("w_dwait_hold", dwait, 1);
        tick(); ram_ready = 1; ram_load = 32'h5555_5555; settle();
        check("w_dwait", dwait, 0);
        check("w_dload", dload, 0);
        tick(); dREN = 0; dWEN = 0; ram_ready = 0; dstore = 0; settle();
        check("w_idle_store", ram_store, 0);
        tick();

        // abort a data read before ready
        dREN = 1; daddr = 32'h300; settle();
        tick(); settle();
        check("a_ren", ram_ren, 1);
        tick(); dREN = 0; settle();
        check("a_drop_ren", ram_ren, 0);
        check("a_drop_wen", ram_wen, 0);
        check("a_drop_dwait", dwait, 1);
        tick(); iREN = 1; iaddr = 32'h44; settle();
        check("a_idle_ren", ram_ren, 0);
        tick(); settle();
        check("a_iacc_ren", ram_ren, 1);
        check("a_iacc_addr", ram_addr, 32'h44);
        ram_ready = 1; settle();
        tick(); iREN = 0; ram_ready = 0;
        tick();

        // reset in the middle of a data access
        dREN = 1; daddr = 32'h400; settle();
        tick(); settle();
        check("r_dacc_ren", ram_ren, 1);
        nRST = 0; settle();
        check("r_iwait", iwait, 1);
        check("r_dwait", dwait, 1);
        check("r_ren", ram_ren, 0);
        check("r_wen", ram_wen, 0);
        tick();
        dREN = 0; iREN = 1; iaddr = 32'h48; nRST = 1; settle();
        check("r_idle_ren", ram_ren, 0);
        tick(); settle();
        check("r_grant_ren", ram_ren, 1);
        check("r_grant_addr", ram_addr, 32'h48);
        ram_ready = 1; settle();
        tick(); iREN = 0; ram_ready = 0;
        tick();

        // continuous data traffic with a pending fetch
        iREN = 1; iaddr = 32'h4C; dREN = 1; daddr = 32'h500; ram_ready = 1; ram_load = 32'h7;
        first_i = -1;
        for (int k = 0; k < 20; k++) begin
            tick(); settle();
            if (!iwait) begin
                first_i = k;
                break;
            end
            tick();
        end
`ifdef MEMORY_ARBITER_STARVE_GUARD_EN
        check("s_first_iacc", first_i, 4);
`else
        check("s_first_iacc", first_i, -1);
`endif
        iREN = 0; dREN = 0; ram_ready = 0;
        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Sequential arbiter that shares the single-ported main RAM between the instruction-fetch port and the data-memory port of the pipelined CPU. It owns a three-state FSM (IDLE / IACC / DACC), gives data accesses priority, and drives the per-port wait signals. The hazard unit uses those wait signals, through ihit/dhit, to stall the pipeline.

## Interface
Parameters:
- ADDR_W, 32, address width (byte address)
- DATA_W, 32, data word width
- STARVE_MAX, 4, consecutive data grants tolerated while a fetch is pending (used only with the starvation guard)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  instruction read request
- iaddr  in  ADDR_W  instruction address
- iwait  out  1  instruction port stalled; low = iload valid this cycle
- iload  out  DATA_W  instruction word
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  write data
- dwait  out  1  data port stalled; low = access completes this cycle
- dload  out  DATA_W  read data
- ram_ren  out  1  RAM read strobe
- ram_wen  out  1  RAM write strobe
- ram_addr  out  ADDR_W  RAM address
- ram_store  out  DATA_W  RAM write data
- ram_load  in  DATA_W  RAM read data
- ram_ready  in  1  RAM has completed the presented access this cycle

## Operation
- Requesters hold address, data and strobes stable until their wait goes low. They may drop the request early, which aborts the access.
- IDLE
  - ram_ren, ram_wen and ram_addr are 0.
  - Arbitration: if dREN|dWEN, go to DACC; else if iREN, go to IACC; else stay in IDLE.
  - ram_ready is ignored in IDLE.
- DACC
  - ram_addr = daddr, ram_store = dstore.
  - dWEN has precedence: if dWEN is high, ram_wen = 1 and ram_ren = 0. Otherwise ram_ren = dREN.
- IACC
  - ram_addr = iaddr, ram_ren = 1, ram_wen = 0, ram_store = 0.
- Completion:
  - In DACC or IACC with ram_ready = 1, the owning port's wait goes low for that cycle.
  - Its load output = ram_load (dload on writes is don't-care and is driven 0).
  - Next state is IDLE.
- Abort:
  - If the owner's request drops while in DACC or IACC, ram strobes go 0 combinationally in that cycle and the next state is IDLE.
  - No wait pulse is produced.
- Waits:
  - iwait = ~(state==IACC & ram_ready); dwait = ~(state==DACC & ram_ready).
  - Both waits are high at all other times, including when the port is idle.
- Loads: iload and dload are 0 except in their own completion cycle.
- Output muxing from the state register is combinational. No output is registered beyond the state.

## Timing
- Reset (asynchronous, nRST low):
  - state = IDLE, starvation counter = 0.
  - Outputs: iwait = 1, dwait = 1, iload = 0, dload = 0, ram_ren = 0, ram_wen = 0, ram_addr = 0, ram_store = 0.
- Reset mid-access: the transfer is dropped immediately, with no wait pulse. After nRST rises, arbitration restarts from IDLE.
- Minimum latency: request seen in IDLE at cycle 0, access state in cycle 1. With ram_ready in cycle 1, wait is low in cycle 1.
- Turnaround: every completion or abort is followed by exactly one IDLE cycle. Back-to-back accesses therefore occupy 2 + (RAM wait cycles) each.
- Simultaneous requests in IDLE go to data, unless the starvation guard overrides.
- A request that arrives while the other port owns the RAM waits until the next IDLE cycle. The owner is never preempted.

## Configuration
- MEMORY_ARBITER_STARVE_GUARD_EN defined:
  - A 3-bit-minimum counter increments on each DACC grant made while iREN is high.
  - When the counter equals STARVE_MAX and iREN is high, the next IDLE arbitration grants IACC even if a data request is pending.
  - The counter clears on any IACC grant, or at any IDLE arbitration where iREN is low.
- Undefined: strict data priority, no counter logic. A fetch can starve indefinitely.

## Test plan
- Reset: drive nRST low mid-DACC with ram_ready = 0 → same cycle iwait = 1, dwait = 1, ram_ren = 0, ram_wen = 0. After release, an iREN request is granted 1 cycle later.
- Single fetch: iREN = 1, iaddr = 0x0000_0040, ram_ready high 2 cycles after grant with ram_load = 0x2408_0005 → iwait low for exactly 1 cycle with iload = 0x2408_0005, then 1 IDLE cycle.
- Collision: iREN, dREN and daddr = 0x0000_0100 asserted together in IDLE → DACC first, dload = ram_load. IACC is granted only after the following IDLE cycle.
- Write precedence: dREN = dWEN = 1, dstore = 0xDEAD_BEEF → ram_wen = 1, ram_ren = 0, ram_store = 0xDEAD_BEEF. dwait is low on ram_ready, with dload = 0.
- Abort: drop dREN in DACC before ram_ready → strobes 0 that cycle, no dwait pulse, state IDLE next cycle.
- Starvation guard (macro defined, STARVE_MAX = 4): dREN held high continuously with iREN high → 4 DACC completions, then an IACC grant. Without the macro, no IACC grant occurs in 20 accesses.
